booth_window_scanner: RTL

// - Consumer side of the radix-4 Booth operand register. Takes the (2*WIDTH+1)-bit extended multiplier window

---
 rtl/booth_window_scanner.sv | 134 +++++++++++++
 1 files changed

// File: rtl/booth_window_scanner.sv
// booth_window_scanner
//   Consumes the extended radix-4 Booth multiplier window that the operand
//   register produces. It scans one Booth triplet per clock, decodes each
//   triplet to a digit in {-2..+2}, and accumulates the shifted partial
//   products into a signed 2*WIDTH product.
//
//   Build option: define BOOTH_EARLY_TERM_EN to finish as soon as the rest of
//   the window holds only zero digits. Without it, the scan always takes
//   WIDTH/2 cycles, so latency is fixed.
//
// Ports
//   clk        rising-edge clock
//   n_rst      synchronous active-low reset
//   i_start    start request, sampled only while idle
//   i_window   extended multiplier: [0]=0, [W:1]=multiplier, [2W:W+1]=sign ext
//   i_mcand    signed multiplicand
//   o_busy     high while scanning and during the done cycle
//   o_done     one-cycle pulse; o_product is valid
//   o_product  signed product, held until the next operation completes
module booth_window_scanner #(
  parameter int WIDTH_REGISTER = 32
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          i_start,
  input  logic [2*WIDTH_REGISTER:0]     i_window,
  input  logic [WIDTH_REGISTER-1:0]     i_mcand,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [2*WIDTH_REGISTER-1:0]   o_product
);

  localparam int W      = WIDTH_REGISTER;
  localparam int PW     = 2 * W;
  localparam int DIGITS = W / 2;
  localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state, next_state;
  logic [PW:0]   win;
  logic [PW-1:0] mcand;
  logic [PW-1:0] acc;
  logic [PW-1:0] acc_next;
  logic [PW-1:0] part;
  logic [PW-1:0] product;
  logic [IW-1:0] idx;
  logic [2:0]    triplet;
  logic          scan_end;

  // The window is shifted right two bits per digit, and the multiplicand is
  // shifted left two bits. The current triplet is therefore always win[2:0],
  // and the multiplicand already carries the 2*idx weight. This avoids any
  // variable shifter.
  always_comb begin
    triplet = win[2:0];
    part    = '0;
    case (triplet)
      3'b001, 3'b010: part = mcand;
      3'b011:         part = mcand << 1;
      3'b100:         part = -(mcand << 1);
      3'b101, 3'b110: part = -mcand;
      default:        part = '0;
    endcase
    acc_next = acc + part;
  end

  // The window is arithmetic-shifted, so the bits above the consumed triplet
  // stay a faithful copy of the original upper window. When they are uniform,
  // every remaining triplet decodes to zero.
  always_comb begin
`ifdef BOOTH_EARLY_TERM_EN
    scan_end = (idx == LAST_IDX) || (&win[PW:2]) || (~|win[PW:2]);
`else
    scan_end = (idx == LAST_IDX);
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_start)  next_state = SCAN;
      SCAN:    if (scan_end) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    o_busy = (state != IDLE);
    o_done = (state == DONE);
  end

  // Datapath: operands are latched on start. The product register is loaded
  // only on the edge that enters DONE, so partial sums never reach the output.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      win     <= '0;
      mcand   <= '0;
      acc     <= '0;
      idx     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          win   <= i_window;
          mcand <= {{W{i_mcand[W-1]}}, i_mcand};
          acc   <= '0;
          idx   <= '0;
        end
        SCAN: begin
          acc   <= acc_next;
          win   <= {{2{win[PW]}}, win[PW:2]};
          mcand <= mcand << 2;
          idx   <= idx + 1'b1;
          if (scan_end) product <= acc_next;
        end
        default: ;
      endcase
    end
  end

  assign o_product = product;

endmodule
